uart_receiver: RTL



---
 rtl/uart_receiver.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// Oversampling UART receiver with FWFT byte FIFO, CTS flow control and
// sticky line-error flags.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   UartTx       asynchronous serial line from host, idle high
//   UartCTS      clear-to-send to host (FIFO has room for two more bytes)
//   ReceiveByte  pop strobe for the FIFO head
//   ClearErrors  clears the sticky error flags
//   DnByte       FIFO head, valid while !DnEmpty
//   DnEmpty      FIFO empty
//   DnFull       FIFO full
//   FrameError   sticky: a stop bit was sampled low
//   ParityError  sticky: a stored byte had bad parity
//   Overrun      sticky: a good byte was dropped on a full FIFO
//   Busy         frame in progress
module uart_receiver #(
    parameter int ClkFrequency = 100000000,
    parameter int BaudRate     = 9600,
    parameter int DataBits     = 8,
    parameter int ParityBit    = 0,
    parameter int StopBits     = 2,
    parameter int FifoDepth    = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                UartTx,
    output logic                UartCTS,
    input  logic                ReceiveByte,
    input  logic                ClearErrors,
    output logic [DataBits-1:0] DnByte,
    output logic                DnEmpty,
    output logic                DnFull,
    output logic                FrameError,
    output logic                ParityError,
    output logic                Overrun,
    output logic                Busy
);

    localparam int Div   = ClkFrequency / (16 * BaudRate);
    localparam int TickW = $clog2(Div);
    localparam int BitW  = $clog2(DataBits);
    localparam int AddrW = $clog2(FifoDepth);

    localparam logic [AddrW:0] FullCount = (AddrW + 1)'(FifoDepth);
    localparam logic [AddrW:0] CtsLimit  = (AddrW + 1)'(FifoDepth - 2);

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Parity,
        Stop
    } state_t;

    state_t              state;
    logic                syncFf;
    logic                rx;
    logic                rxPrev;
    logic [TickW-1:0]    tickCnt;
    logic [3:0]          sampleCnt;
    logic [BitW-1:0]     bitCnt;
    logic                stopCnt;
    logic [DataBits-1:0] shiftReg;
    logic                parityBad;

    logic tick;
    logic midpoint;
    logic startEdge;
    logic lastStop;
    logic pushReq;
    logic frameErr;

    logic [DataBits-1:0] mem [FifoDepth];
    logic [AddrW:0]      wrPtr;
    logic [AddrW:0]      rdPtr;
    logic [AddrW:0]      count;
    logic                pop;
    logic                push;
    logic                dropped;

    assign tick      = (tickCnt == TickW'(Div - 1));
    assign midpoint  = tick && (sampleCnt == 4'd7);
    assign startEdge = (state == Idle) && rxPrev && !rx;
    assign lastStop  = (stopCnt == 1'(StopBits - 1));
    assign pushReq   = midpoint && (state == Stop) && rx && lastStop;
    assign frameErr  = midpoint && (state == Stop) && !rx;

    // Two-flop synchroniser plus one more stage for edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            syncFf <= 1'b1;
            rx     <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            syncFf <= UartTx;
            rx     <= syncFf;
            rxPrev <= rx;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= Idle;
            tickCnt   <= '0;
            sampleCnt <= '0;
            bitCnt    <= '0;
            stopCnt   <= 1'b0;
            shiftReg  <= '0;
            parityBad <= 1'b0;
        end else begin
            tickCnt <= tick ? '0 : tickCnt + 1'b1;
            if (tick) begin
                sampleCnt <= sampleCnt + 4'd1;
            end
            unique case (state)
                Idle: begin
                    // Realign the oversampling grid to the start edge.
                    if (startEdge) begin
                        state     <= Start;
                        tickCnt   <= '0;
                        sampleCnt <= '0;
                    end
                end
                Start: begin
                    if (midpoint) begin
                        if (!rx) begin
                            state     <= Data;
                            bitCnt    <= '0;
                            parityBad <= 1'b0;
                        end else begin
                            state <= Idle;
                        end
                    end
                end
                Data: begin
                    if (midpoint) begin
                        shiftReg <= {rx, shiftReg[DataBits-1:1]};
                        bitCnt   <= bitCnt + 1'b1;
                        if (bitCnt == BitW'(DataBits - 1)) begin
                            bitCnt  <= '0;
                            stopCnt <= 1'b0;
                            state   <= (ParityBit != 0) ? Parity : Stop;
                        end
                    end
                end
                Parity: begin
                    // Odd: data plus parity must hold an odd count of ones.
                    if (midpoint) begin
                        parityBad <= (((^shiftReg) ^ rx) != (ParityBit == 1));
                        state     <= Stop;
                    end
                end
                Stop: begin
                    if (midpoint) begin
                        if (!rx || lastStop) begin
                            state <= Idle;
                        end else begin
                            stopCnt <= stopCnt + 1'b1;
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

    assign count   = wrPtr - rdPtr;
    assign DnEmpty = (count == '0);
    assign DnFull  = (count == FullCount);
    assign UartCTS = (count <= CtsLimit);
    assign pop     = ReceiveByte && !DnEmpty;
    assign push    = pushReq && (!DnFull || pop);
    assign dropped = pushReq && DnFull && !pop;
    assign DnByte  = DnEmpty ? '0 : mem[rdPtr[AddrW-1:0]];
    assign Busy    = (state != Idle);

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wrPtr[AddrW-1:0]] <= shiftReg;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    // A new error event beats a simultaneous clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FrameError  <= 1'b0;
            ParityError <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            if (frameErr) begin
                FrameError <= 1'b1;
            end else if (ClearErrors) begin
                FrameError <= 1'b0;
            end
            if (pushReq && parityBad) begin
                ParityError <= 1'b1;
            end else if (ClearErrors) begin
                ParityError <= 1'b0;
            end
            if (dropped) begin
                Overrun <= 1'b1;
            end else if (ClearErrors) begin
                Overrun <= 1'b0;
            end
        end
    end

endmodule
